// File: rtl/onehot_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder_pkg
// Description : Shared types and constants for the registered one-hot decoder
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_decoder_pkg;

    // Width of the per-slot hold counter (HOLD_CYCLES up to 255)
    localparam int DEC_CNT_W = 8;

    // Value driven on y whenever no code or scan slot is active
    localparam logic [3:0] DEC_IDLE_Y = 4'b0000;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } dec_state_t;

endpackage : onehot_decoder_pkg
`default_nettype wire

// File: rtl/decoder_2to4_comb.sv
`default_nettype none
// ============================================================================
// Module      : decoder_2to4_comb
// Description : Pure combinational 2-bit code to 4-bit one-hot table
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_2to4_comb (
    input  logic [1:0] code,
    output logic [3:0] onehot
);

    // Table lookup; every code maps to exactly one asserted line
    always_comb begin
        onehot = 4'b0000;
        case (code)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            default: onehot = 4'b1000;
        endcase
    end

endmodule : decoder_2to4_comb
`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder_seq
// Description : Registered 2-to-4 one-hot decoder with valid/ready accept,
//               per-code hold timing and a free-running scan mode
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder_seq
    import onehot_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_code,
    input  logic       scan_en,
    output logic [3:0] y,
    output logic       busy,
    output logic       done
);

    localparam logic [DEC_CNT_W-1:0] C_RELOAD = DEC_CNT_W'(HOLD_CYCLES - 1);

    dec_state_t           r_state;
    dec_state_t           w_state_nxt;
    logic [DEC_CNT_W-1:0] r_cnt;
    logic [DEC_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]           r_y;
    logic [3:0]           w_y_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [3:0]           w_decoded;
    logic                 w_accept;

    decoder_2to4_comb u_dec (
        .code   (in_code),
        .onehot (w_decoded)
    );

    // Ready only from a settled IDLE, never while scan is requested or in reset
    assign in_ready = (r_state == IDLE) & ~scan_en & rst_n;
    assign w_accept = in_valid & in_ready;

    assign y    = r_y;
    assign done = r_done;
    assign busy = (r_state != IDLE);

    // Next-state, counter and output-register decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_y_nxt     = r_y;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_y_nxt     = w_decoded;
                    w_cnt_nxt   = C_RELOAD;
                    w_state_nxt = HOLD;
                end else if (scan_en) begin
                    w_y_nxt     = 4'b0001;
                    w_cnt_nxt   = C_RELOAD;
                    w_state_nxt = SCAN;
                end
            end
            HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_y_nxt     = DEC_IDLE_Y;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            SCAN: begin
                // scan_en is only looked at on slot boundaries so slots are never cut short
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (scan_en) begin
                    w_y_nxt   = {r_y[2:0], r_y[3]};
                    w_cnt_nxt = C_RELOAD;
                end else begin
                    w_y_nxt     = DEC_IDLE_Y;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_y_nxt     = DEC_IDLE_Y;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_y     <= DEC_IDLE_Y;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_y_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule : onehot_decoder_seq
`default_nettype wire

// File: tb/tb_onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_decoder_seq
// Description : Directed self-checking bench for onehot_decoder_seq
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, scan_en;
    logic [1:0] in_code;
    logic       in_ready, busy, done;
    logic [3:0] y;

    logic       in_valid2, scan_en2;
    logic [1:0] in_code2;
    logic       in_ready2, busy2, done2;
    logic [3:0] y2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    onehot_decoder_seq #(.HOLD_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .scan_en(scan_en), .y(y), .busy(busy), .done(done)
    );

    onehot_decoder_seq #(.HOLD_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_code(in_code2), .scan_en(scan_en2), .y(y2), .busy(busy2), .done(done2)
    );

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] codes [3];
        logic [3:0] exp_y [3];
        logic [3:0] scan_seq [10];
        codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b11;
        exp_y[0] = 4'b0001; exp_y[1] = 4'b0010; exp_y[2] = 4'b1000;
        scan_seq[0] = 4'b0001; scan_seq[1] = 4'b0001; scan_seq[2] = 4'b0010;
        scan_seq[3] = 4'b0010; scan_seq[4] = 4'b0100; scan_seq[5] = 4'b0100;
        scan_seq[6] = 4'b1000; scan_seq[7] = 4'b1000; scan_seq[8] = 4'b0001;
        scan_seq[9] = 4'b0001;

        rst_n = 1'b0; in_valid = 1'b0; scan_en = 1'b0; in_code = 2'b00;
        in_valid2 = 1'b0; scan_en2 = 1'b0; in_code2 = 2'b00;

        // Reset
        tick();
        tick();
        check_val("rst_y", 8'(y), 8'h0);
        check_val("rst_busy", 8'(busy), 8'h0);
        check_val("rst_done", 8'(done), 8'h0);
        check_val("rst_ready", 8'(in_ready), 8'h0);
        rst_n = 1'b1;
        #1;
        check_val("idle_ready", 8'(in_ready), 8'h1);
        tick();
        check_val("idle_y", 8'(y), 8'h0);
        check_val("idle_busy", 8'(busy), 8'h0);

        // Single accept of code 2
        in_valid = 1'b1; in_code = 2'b10;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_code = 2'(i);
            check_val("hold_y", 8'(y), 8'h04);
            check_val("hold_done", 8'(done), 8'h0);
            check_val("hold_busy", 8'(busy), 8'h1);
            tick();
        end
        check_val("end_y", 8'(y), 8'h0);
        check_val("end_done", 8'(done), 8'h1);
        check_val("end_ready", 8'(in_ready), 8'h1);
        tick();
        check_val("done_pulse", 8'(done), 8'h0);

        // Back-to-back codes with in_valid held high
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_code = codes[c];
            tick();
            if (c == 2) in_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check_val("b2b_y", 8'(y), 8'(exp_y[c]));
                check_val("b2b_ready", 8'(in_ready), 8'h0);
                tick();
            end
            check_val("b2b_gap_y", 8'(y), 8'h0);
            check_val("b2b_gap_ready", 8'(in_ready), 8'h1);
        end
        tick();

        // scan_en and in_valid together: scan wins
        scan_en = 1'b1; in_valid = 1'b1; in_code = 2'b11;
        #1;
        check_val("prio_ready", 8'(in_ready), 8'h0);
        tick();
        check_val("prio_y", 8'(y), 8'h01);
        check_val("prio_busy", 8'(busy), 8'h1);
        scan_en = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("prio_slot_y", 8'(y), 8'h01);
        end
        tick();
        check_val("prio_exit_y", 8'(y), 8'h0);
        check_val("prio_exit_done", 8'(done), 8'h0);
        check_val("prio_exit_busy", 8'(busy), 8'h0);

        // Reset during third cycle of a HOLD
        in_valid = 1'b1; in_code = 2'b01;
        tick();
        in_valid = 1'b0;
        check_val("rsth_y", 8'(y), 8'h02);
        tick();
        tick();
        check_val("rsth_y3", 8'(y), 8'h02);
        rst_n = 1'b0;
        tick();
        check_val("rsth_y_after", 8'(y), 8'h0);
        check_val("rsth_done", 8'(done), 8'h0);
        check_val("rsth_busy", 8'(busy), 8'h0);
        check_val("rsth_ready", 8'(in_ready), 8'h0);
        rst_n = 1'b1;
        tick();
        check_val("rsth_post_done", 8'(done), 8'h0);
        check_val("rsth_post_ready", 8'(in_ready), 8'h1);

        // Scan mode with HOLD_CYCLES=2, scan_en dropped mid-slot
        scan_en2 = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check_val("scan_y", 8'(y2), 8'(scan_seq[i]));
            check_val("scan_done", 8'(done2), 8'h0);
            if (i == 8) scan_en2 = 1'b0;
            tick();
        end
        check_val("scan_exit_y", 8'(y2), 8'h0);
        check_val("scan_exit_done", 8'(done2), 8'h0);
        check_val("scan_exit_busy", 8'(busy2), 8'h0);
        check_val("scan_exit_ready", 8'(in_ready2), 8'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_onehot_decoder_seq
`default_nettype wire

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Registered 2-to-4 one-hot decoder with valid/ready input handshake and per-code hold timing. Accepts a 2-bit code `in_code` and drives the matching one-hot line on `y` for exactly `HOLD_CYCLES` cycles, then returns `y` to zero. It also provides a free-running scan mode that walks `y` through all four lines, for example for digit-select of a multiplexed display. It is the decode-side counterpart of the team's 4:2 encoder and sits between a code source and one-hot select lines.

## Interface
- `HOLD_CYCLES`, default 4: cycles each one-hot value is held on `y`. Legal range 1..255.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset: one clock; reset is synchronous and active-low.
- `in_valid`  in  1  `in_code` is valid this cycle.
- `in_ready`  out  1  block can accept a code this cycle.
- `in_code`  in  2  code to decode; sampled only on accept.
- `scan_en`  in  1  request scan mode; level-sensitive.
- `y`  out  4  registered one-hot output, or 4'b0000 when idle.
- `busy`  out  1  high when the state is not IDLE.
- `done`  out  1  one-cycle pulse when a single-code hold completes.

## Operation
- Reset values when `rst_n`=0 at an edge:
  - State goes to IDLE, hold counter to 0, `y`=0000, `done`=0.
  - `busy`=0.
  - `in_ready` is forced to 0 while `rst_n` is low.
- `in_ready` = (state==IDLE) & !`scan_en` & `rst_n`. It is combinational from registered state.
- Accept occurs when `in_valid` & `in_ready` are both high at a rising edge.
- States: IDLE, HOLD, SCAN.
- **IDLE**
  - On accept: `y` <= 1<<`in_code`, counter <= HOLD_CYCLES-1, go to HOLD.
  - Otherwise, if `scan_en`=1: `y` <= 0001, counter <= HOLD_CYCLES-1, go to SCAN.
  - `scan_en` has priority because it deasserts `in_ready`. A simultaneous `in_valid` is not accepted.
- **HOLD**
  - `y` is stable and `scan_en` is ignored.
  - While counter != 0, the counter decrements.
  - When counter==0: `y` <= 0000, `done` <= 1 for one cycle, go to IDLE.
- **SCAN**
  - While counter != 0, the counter decrements.
  - When counter==0 and `scan_en`=1: `y` rotates left and the counter reloads. The wrap is 1000 -> 0001.
  - When counter==0 and `scan_en`=0: `y` <= 0000, go to IDLE, no `done` pulse.
  - Deasserting `scan_en` mid-slot completes the current slot; it does not truncate it.
- `y` is always one-hot or zero; any other value is a design error.
- Counter is 8 bits unsigned. It never underflows because the reload happens at zero.
- Reset mid-HOLD or mid-SCAN: the next edge with `rst_n`=0 sets `y`=0000 immediately. No `done` pulse is emitted and any pending code is dropped.

## Timing
- Accept at edge k gives `y` = decoded value after edge k, through edge k+HOLD_CYCLES-1. That is exactly HOLD_CYCLES cycles.
- After edge k+HOLD_CYCLES: `y`=0000, `done`=1 and `in_ready`=1 (if `scan_en`=0), all in the same cycle.
- Back-to-back codes therefore produce one zero cycle between holds. Throughput is one code per HOLD_CYCLES+1 cycles.
- HOLD_CYCLES=1: `y` is asserted for a single cycle. The counter loads 0 and the block exits on the next edge.
- Scan: each slot lasts HOLD_CYCLES cycles; a full rotation takes 4*HOLD_CYCLES cycles.
- `in_code` is don't-care when no accept occurs. `in_code` changes during HOLD have no effect.

## Structure
- Package `onehot_decoder_pkg` holds:
  - state typedef `dec_state_t` (IDLE, HOLD, SCAN);
  - constant `DEC_IDLE_Y` = 4'b0000;
  - localparam `DEC_CNT_W` = 8.
- Sub-module `decoder_2to4_comb` is the pure combinational 2-bit -> one-hot table. It is instantiated once and feeds the `y` register on accept.
- Top level contains the FSM, the hold counter and the `y`/`done` registers.

## Test plan
- Reset, then idle with HOLD_CYCLES=4: `y`=0000, `busy`=0, `done`=0; `in_ready` is 0 during reset and 1 after.
- Accept `in_code`=2'b10 with HOLD_CYCLES=4: `y`=0100 for 4 cycles; then `y`=0000 and `done`=1 for exactly 1 cycle.
- Hold `in_valid`=1 and cycle codes 00, 01, 11 back-to-back: `y` shows 0001, 0000, 0010, 0000, 1000, with each code held 4 cycles. `in_ready` is high only in the zero cycles.
- Scan with HOLD_CYCLES=2 and `scan_en` high for 10 cycles: `y` shows 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0001. When `scan_en` drops mid-slot, the slot completes and `y` returns to 0000 without a `done` pulse.
- `scan_en` and `in_valid` both asserted in IDLE: the code is not accepted (`in_ready`=0) and SCAN starts with `y`=0001.
- `rst_n` low during the third cycle of a HOLD: `y`=0000 after that edge, no `done` pulse, IDLE entered.
